// File: rtl/delayed_network_source_pkg.sv
// Shared opcode encoding, instruction field width helpers and charge saturation
// for the delayed network source front end.
package source_sched_config;

  localparam int unsigned NET_NUM_INP      = 4;
  localparam int unsigned NET_CHARGE_WIDTH = 8;

  localparam int unsigned NUM_OPCODES = 5;
  localparam int unsigned OPC_WIDTH   = $clog2(NUM_OPCODES);

  typedef enum logic [OPC_WIDTH-1:0] {
    NOP,
    RUN,
    SPK,
    CLR,
    NUM_OPS
  } opcode_t;

  function automatic int unsigned idx_w(input int unsigned num_inp);
    return (num_inp > 1) ? $clog2(num_inp) : 1;
  endfunction

  function automatic int unsigned dly_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Payload below the opcode: wide enough for a RUN count or a full SPK tuple.
  function automatic int unsigned pay_w(input int unsigned num_inp, input int unsigned depth,
                                        input int unsigned cw, input int unsigned run_w);
    int unsigned spk_w;
    spk_w = idx_w(num_inp) + dly_w(depth) + cw;
    return (run_w > spk_w) ? run_w : spk_w;
  endfunction

  function automatic int unsigned src_w(input int unsigned num_inp, input int unsigned depth,
                                        input int unsigned cw, input int unsigned run_w);
    return OPC_WIDTH + pay_w(num_inp, depth, cw, run_w);
  endfunction

  // Signed add clamped to the range of a cw-bit two's complement charge.
  function automatic int sat_add(input int a, input int b, input int unsigned cw);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (cw - 1)) - 1;
    lo  = -hi - 1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/delayed_network_source_ring.sv
// Ring of future input frames: head frame is presented, cleared on consume,
// and one charge write per cycle lands relative to the post-advance head.
module spike_delay_ring
  import source_sched_config::*;
#(
  parameter int unsigned NUM_INP      = NET_NUM_INP,
  parameter int unsigned CHARGE_WIDTH = NET_CHARGE_WIDTH,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ACCUMULATE   = 1
) (
  input  logic                                   clk,
  input  logic                                   arstn,
  input  logic                                   clr_i,
  input  logic                                   consume_i,
  input  logic                                   wr_en_i,
  input  logic [idx_w(NUM_INP)-1:0]              wr_idx_i,
  input  logic [dly_w(DEPTH)-1:0]                wr_dly_i,
  input  logic [CHARGE_WIDTH-1:0]                wr_val_i,
  output logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]   frame_c_o
);

  localparam int unsigned DLY_W = dly_w(DEPTH);
  localparam int unsigned SUM_W = DLY_W + 1;

  typedef logic [NUM_INP-1:0][CHARGE_WIDTH-1:0] frame_t;

  frame_t [DEPTH-1:0] slots_q;
  frame_t [DEPTH-1:0] slots_d;
  logic   [DLY_W-1:0] head_q;
  logic   [DLY_W-1:0] head_d;
  logic   [DLY_W-1:0] head_eff;
  logic   [DLY_W-1:0] tgt;
  logic   [SUM_W-1:0] tgt_sum;

  // Head after any same-cycle advance, and the write slot relative to it.
  always_comb begin
    head_eff = head_q;
    if (consume_i) begin
      head_eff = (32'(head_q) == DEPTH - 1) ? '0 : head_q + 1'b1;
    end
    tgt_sum = {1'b0, head_eff} + {1'b0, wr_dly_i};
    if (32'(tgt_sum) >= DEPTH) begin
      tgt_sum = tgt_sum - SUM_W'(DEPTH);
    end
    tgt = tgt_sum[DLY_W-1:0];
  end

  // Consume clears first so a write into the vacated slot starts from zero.
  always_comb begin
    slots_d = slots_q;
    head_d  = head_eff;
    if (consume_i) begin
      slots_d[head_q] = '0;
    end
    if (wr_en_i) begin
      if (ACCUMULATE != 0) begin
        slots_d[tgt][wr_idx_i] = CHARGE_WIDTH'(sat_add(int'($signed(slots_d[tgt][wr_idx_i])),
                                                       int'($signed(wr_val_i)), CHARGE_WIDTH));
      end else begin
        slots_d[tgt][wr_idx_i] = wr_val_i;
      end
    end
    if (clr_i) begin
      slots_d = '0;
      head_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      slots_q <= '0;
      head_q  <= '0;
    end else begin
      slots_q <= slots_d;
      head_q  <= head_d;
    end
  end

  assign frame_c_o = slots_q[head_q];

endmodule

// File: rtl/delayed_network_source.sv
// Dispatch-stream front end: decodes NOP/RUN/SPK/CLR, schedules spike charges
// into a delay ring and steps the network one frame per consumed cycle.
module delayed_network_source
  import source_sched_config::*;
#(
  parameter int unsigned NUM_INP      = NET_NUM_INP,
  parameter int unsigned CHARGE_WIDTH = NET_CHARGE_WIDTH,
  parameter int unsigned RUN_WIDTH    = 16,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ACCUMULATE   = 1
) (
  input  logic                                                     clk,
  input  logic                                                     arstn,
  input  logic                                                     src_valid,
  output logic                                                     src_ready,
  input  logic [src_w(NUM_INP, DEPTH, CHARGE_WIDTH, RUN_WIDTH)-1:0] src,
  input  logic                                                     net_ready,
  output logic                                                     net_valid,
  output logic                                                     net_arstn,
  output logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]                     net_inp,
  output logic                                                     err
);

  localparam int unsigned IDX_W     = idx_w(NUM_INP);
  localparam int unsigned DLY_W     = dly_w(DEPTH);
  localparam int unsigned PAY_W     = pay_w(NUM_INP, DEPTH, CHARGE_WIDTH, RUN_WIDTH);
  localparam int unsigned SRC_WIDTH = src_w(NUM_INP, DEPTH, CHARGE_WIDTH, RUN_WIDTH);

  logic [OPC_WIDTH-1:0]    opc;
  logic [RUN_WIDTH-1:0]    run_cnt;
  logic [IDX_W-1:0]        spk_idx;
  logic [DLY_W-1:0]        spk_dly;
  logic [CHARGE_WIDTH-1:0] spk_val;
  logic                    spk_ok;

  logic [RUN_WIDTH-1:0]    run_q;
  logic [RUN_WIDTH-1:0]    run_d;
  logic                    err_q;
  logic                    err_d;
  logic                    net_arstn_q;
  logic                    net_arstn_d;

  logic                    accept;
  logic                    consume;
  logic                    is_run;
  logic                    is_spk;
  logic                    is_clr;

  // Fields are packed MSB-first directly under the opcode.
  assign opc     = src[SRC_WIDTH-1 -: OPC_WIDTH];
  assign run_cnt = src[PAY_W-1 -: RUN_WIDTH];
  assign spk_idx = src[PAY_W-1 -: IDX_W];
  assign spk_dly = src[PAY_W-1-IDX_W -: DLY_W];
  assign spk_val = src[PAY_W-1-IDX_W-DLY_W -: CHARGE_WIDTH];
  assign spk_ok  = (32'(spk_idx) < NUM_INP) && (32'(spk_dly) < DEPTH);

  assign net_valid = (run_q != '0);
  assign consume   = net_valid & net_ready;
  assign src_ready = (run_q == '0) | ((run_q == RUN_WIDTH'(1)) & net_ready);
  assign accept    = src_valid & src_ready;

  always_comb begin
    is_run = 1'b0;
    is_spk = 1'b0;
    is_clr = 1'b0;
    if (accept) begin
      case (opc)
        RUN:     is_run = 1'b1;
        SPK:     is_spk = 1'b1;
        CLR:     is_clr = 1'b1;
        default: ;
      endcase
    end
  end

  // A RUN landing on the final consume overrides the decrement: no bubble.
  always_comb begin
    run_d       = run_q;
    err_d       = err_q;
    net_arstn_d = ~is_clr;
    if (consume) begin
      run_d = run_q - 1'b1;
    end
    if (is_run) begin
      run_d = (run_cnt == '0) ? RUN_WIDTH'(1) : run_cnt;
    end
    if (is_spk && !spk_ok) begin
      err_d = 1'b1;
    end
    if (is_clr) begin
      run_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      run_q       <= '0;
      err_q       <= 1'b0;
      net_arstn_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      err_q       <= err_d;
      net_arstn_q <= net_arstn_d;
    end
  end

  spike_delay_ring #(
    .NUM_INP      (NUM_INP),
    .CHARGE_WIDTH (CHARGE_WIDTH),
    .DEPTH        (DEPTH),
    .ACCUMULATE   (ACCUMULATE)
  ) u_ring (
    .clk       (clk),
    .arstn     (arstn),
    .clr_i     (is_clr),
    .consume_i (consume),
    .wr_en_i   (is_spk & spk_ok),
    .wr_idx_i  (spk_idx),
    .wr_dly_i  (spk_dly),
    .wr_val_i  (spk_val),
    .frame_c_o (net_inp)
  );

  assign err       = err_q;
  assign net_arstn = net_arstn_q;

endmodule

// File: tb/tb_delayed_network_source.sv
// Bench for delayed_network_source: directed scenarios plus random instruction
// streams, checked against a relative-time future-frame model.
module tb_delayed_network_source;

  localparam int NI  = 3;
  localparam int CW  = 8;
  localparam int RW  = 8;
  localparam int DP  = 6;
  localparam int IW  = 2;
  localparam int DW  = 3;
  localparam int PAY = 13;
  localparam int SW  = 16;

  localparam int OP_NOP = 0;
  localparam int OP_RUN = 1;
  localparam int OP_SPK = 2;
  localparam int OP_CLR = 3;

  logic                  clk = 1'b0;
  logic                  arstn = 1'b0;
  logic                  src_valid = 1'b0;
  logic                  net_ready = 1'b0;
  logic [SW-1:0]         src = '0;
  logic                  src_ready;
  logic                  net_valid;
  logic                  net_arstn;
  logic                  err;
  logic [NI-1:0][CW-1:0] net_inp;

  always #5 clk = ~clk;

  delayed_network_source #(
    .NUM_INP      (NI),
    .CHARGE_WIDTH (CW),
    .RUN_WIDTH    (RW),
    .DEPTH        (DP),
    .ACCUMULATE   (1)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src       (src),
    .net_ready (net_ready),
    .net_valid (net_valid),
    .net_arstn (net_arstn),
    .net_inp   (net_inp),
    .err       (err)
  );

  // m_fut[k] is the frame presented k consumes from now.
  int m_fut [DP][NI];
  int m_run;
  bit m_err;
  bit m_narst;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int inp(input int i);
    return int'($signed(net_inp[i]));
  endfunction

  function automatic int sat(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic logic [SW-1:0] enc(input int op, input int a, input int b, input int c);
    logic [SW-1:0] w;
    w = SW'(op) << PAY;
    if (op == OP_RUN) w = w | (SW'(a) << (PAY - RW));
    else if (op == OP_SPK)
      w = w | (SW'(a) << (PAY - IW)) | (SW'(b) << (PAY - IW - DW)) | SW'(c & 255);
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < DP; d++)
      for (int i = 0; i < NI; i++) m_fut[d][i] = 0;
    m_run   = 0;
    m_err   = 1'b0;
    m_narst = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    chk($sformatf("%s net_valid", tag), int'(net_valid), int'(m_run > 0));
    chk($sformatf("%s net_arstn", tag), int'(net_arstn), int'(m_narst));
    chk($sformatf("%s err", tag), int'(err), int'(m_err));
    for (int i = 0; i < NI; i++)
      chk($sformatf("%s net_inp[%0d]", tag, i), inp(i), m_fut[0][i]);
  endtask

  // Drive one cycle, check the combinational ready, advance the model, check registered outputs.
  task automatic step(input logic v, input logic [SW-1:0] w, input logic nr);
    int op, cnt, idx, dly, val;
    bit rdy, cons, acc;
    src_valid = v;
    src       = w;
    net_ready = nr;
    #1;
    rdy = (m_run == 0) || (m_run == 1 && nr);
    chk("src_ready", int'(src_ready), int'(rdy));
    op   = int'(w[15:13]);
    cnt  = int'(w[12:5]);
    idx  = int'(w[12:11]);
    dly  = int'(w[10:8]);
    val  = int'($signed(w[7:0]));
    cons = (m_run > 0) && nr;
    acc  = v && rdy;
    m_narst = !(acc && op == OP_CLR);
    if (cons) begin
      for (int d = 0; d < DP - 1; d++) m_fut[d] = m_fut[d + 1];
      for (int i = 0; i < NI; i++) m_fut[DP - 1][i] = 0;
      m_run--;
    end
    if (acc) begin
      case (op)
        OP_RUN: m_run = (cnt == 0) ? 1 : cnt;
        OP_SPK: begin
          if (idx < NI && dly < DP) m_fut[dly][idx] = sat(m_fut[dly][idx] + val);
          else m_err = 1'b1;
        end
        OP_CLR: begin
          for (int d = 0; d < DP; d++)
            for (int i = 0; i < NI; i++) m_fut[d][i] = 0;
          m_run = 0;
          m_err = 1'b0;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  int frames [5];
  int exp_frames [5] = '{0, 0, 0, 7, 0};

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    chk("lit reset net_arstn", int'(net_arstn), 0);
    arstn = 1'b1;

    // Immediate spike on input 1, one-frame run.
    step(1'b1, enc(OP_SPK, 1, 0, 5), 1'b1);
    chk("lit net_arstn released", int'(net_arstn), 1);
    step(1'b1, enc(OP_RUN, 1, 0, 0), 1'b1);
    chk("lit run1 valid", int'(net_valid), 1);
    chk("lit run1 inp1", inp(1), 5);
    chk("lit run1 inp0", inp(0), 0);
    step(1'b0, '0, 1'b1);
    chk("lit run1 done valid", int'(net_valid), 0);
    chk("lit run1 slot cleared", inp(1), 0);

    // Delay 3 surfaces on the 4th frame only.
    step(1'b1, enc(OP_SPK, 0, 3, 7), 1'b0);
    step(1'b1, enc(OP_RUN, 5, 0, 0), 1'b1);
    for (int k = 0; k < 5; k++) begin
      frames[k] = inp(0);
      if (k < 4) step(1'b0, '0, 1'b1);
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("lit dly3 frame%0d", k + 1), frames[k], exp_frames[k]);
    step(1'b0, '0, 1'b1);

    // Saturating accumulation.
    step(1'b1, enc(OP_SPK, 2, 0, 100), 1'b0);
    step(1'b1, enc(OP_SPK, 2, 0, 100), 1'b0);
    chk("lit sat inp2", inp(2), 127);
    step(1'b1, enc(OP_RUN, 1, 0, 0), 1'b1);
    step(1'b0, '0, 1'b1);

    // Write into the slot vacated by the final consume: no stale 50.
    step(1'b1, enc(OP_SPK, 0, 0, 50), 1'b0);
    step(1'b1, enc(OP_RUN, 1, 0, 0), 1'b0);
    chk("lit pre-conflict inp0", inp(0), 50);
    step(1'b1, enc(OP_SPK, 0, DP - 1, 9), 1'b1);
    step(1'b1, enc(OP_RUN, 6, 0, 0), 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
    chk("lit conflict frame6 inp0", inp(0), 9);
    chk("lit conflict frame6 valid", int'(net_valid), 1);
    step(1'b0, '0, 1'b1);

    // Malformed spikes set err; CLR clears it and pulses net_arstn.
    step(1'b1, enc(OP_SPK, NI, 0, 1), 1'b0);
    chk("lit bad idx err", int'(err), 1);
    step(1'b1, enc(OP_SPK, 0, DP, 1), 1'b0);
    chk("lit bad dly inp0", inp(0), 0);
    step(1'b1, enc(OP_CLR, 0, 0, 0), 1'b0);
    chk("lit clr err", int'(err), 0);
    chk("lit clr net_arstn low", int'(net_arstn), 0);
    step(1'b0, '0, 1'b0);
    chk("lit clr net_arstn high", int'(net_arstn), 1);

    // Asynchronous reset in the middle of a run.
    step(1'b1, enc(OP_SPK, 1, 2, 33), 1'b0);
    step(1'b1, enc(OP_RUN, 10, 0, 0), 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
    arstn = 1'b0;
    #1;
    model_reset();
    compare_all("midreset");
    chk("lit midreset valid", int'(net_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    step(1'b1, enc(OP_RUN, 1, 0, 0), 1'b0);
    chk("lit post-reset valid", int'(net_valid), 1);
    chk("lit post-reset inp1", inp(1), 0);
    step(1'b0, '0, 1'b1);

    // Random instruction stream.
    for (int n = 0; n < 3000; n++) begin
      int sel, op, a, b, c;
      logic v;
      sel = int'($urandom_range(99));
      if (sel < 10) op = OP_NOP;
      else if (sel < 35) op = OP_RUN;
      else if (sel < 97) op = OP_SPK;
      else op = OP_CLR;
      if (op == OP_RUN) a = int'($urandom_range(7));
      else a = ($urandom_range(19) == 0) ? NI : int'($urandom_range(NI - 1));
      b = ($urandom_range(19) == 0) ? int'($urandom_range(7, DP)) : int'($urandom_range(DP - 1));
      c = int'($urandom_range(255));
      v = ($urandom_range(9) < 7);
      step(v, enc(op, a, b, c), $urandom_range(3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delayed_network_source.md
# delayed_network_source

Instruction-stream front end that feeds spike charges into the network, driven by the host dispatch stream. It decodes NOP/RUN/SPK/CLR instructions and holds a ring of future input frames, so a spike can be scheduled up to DEPTH-1 network cycles ahead. Charges landing in the same input and cycle either accumulate with saturation or overwrite. It sits between the dispatch deserialiser (src side) and the network core (net side).

## Interface
- NUM_INP, default NET_NUM_INP: network input count.
- CHARGE_WIDTH, default NET_CHARGE_WIDTH: signed charge width.
- RUN_WIDTH, default 16: RUN count field width.
- DEPTH, default 8: frame-ring slots (≥1); maximum spike delay DEPTH-1.
- ACCUMULATE, default 1: 1 = saturating add into slot; 0 = overwrite.
- clk  in  1  clock.
- arstn  in  1  reset, asynchronous, active-low.
- src_valid  in  1  instruction valid.
- src_ready  out  1  instruction accepted when src_valid & src_ready.
- src  in  SRC_WIDTH  instruction word.
- net_ready  in  1  network consumes a frame.
- net_valid  out  1  frame on net_inp is valid.
- net_arstn  out  1  network reset, active-low, registered.
- net_inp  out  CHARGE_WIDTH signed × NUM_INP  head-slot frame.
- err  out  1  sticky malformed-spike flag.

## Operation
- Widths: IDX_W = max(1, clog2(NUM_INP)); DLY_W = max(1, clog2(DEPTH)); SRC_WIDTH = OPC_WIDTH + max(RUN_WIDTH, IDX_W+DLY_W+CHARGE_WIDTH). Opcode sits in the MSBs; fields pack MSB-first below it.
- NOP: no effect.
- RUN [count]: run_counter ← max(count, 1).
- SPK [idx][dly][val]: target slot = (head_eff + dly) mod DEPTH, input idx. ACCUMULATE=1: slot ← sat(slot + val), clamped to [-2^(CW-1), 2^(CW-1)-1]. ACCUMULATE=0: slot ← val.
- SPK error cases: if idx ≥ NUM_INP or dly ≥ DEPTH, the spike is dropped and err is set.
- CLR: all slots ← 0, head ← 0, run_counter ← 0, err ← 0, net_arstn low for one cycle.
- Consumption (net_valid & net_ready): head slot ← 0, head ← (head+1) mod DEPTH, run_counter −1.
- head_eff is the head value after any same-cycle consumption advance.
- Same-cycle clear/write conflict: if a SPK targets the slot being cleared by consumption (dly = DEPTH-1 during a consume), the write wins and slot ← val (no stale accumulation).
- A RUN accepted in the same cycle as the final consume loads the new count; there is no bubble.

## Timing
- Reset values: run_counter 0, head 0, all slots 0, err 0, net_arstn 0. net_arstn goes to 1 on the first clk after arstn deasserts.
- src_ready = (run_counter == 0) | (run_counter == 1 & net_ready). This is a combinational path from net_ready.
- net_valid = (run_counter > 0). net_inp = slot[head], a mux from registered storage.
- SPK latency: a spike accepted in cycle t with dly=0 appears on net_inp at t+1.
- The network is stepped only by RUN. Scheduled spikes wait in the ring until consumed; they are not lost while idle.
- Reset mid-run: everything returns to reset values immediately (asynchronous). No partial frame survives.
- Wrap-around: head wraps DEPTH-1 → 0. When DEPTH=1, only dly=0 is legal.

## Structure
- Package source_sched_config holds:
  - opcode_t {NOP, RUN, SPK, CLR, NUM_OPS}
  - OPC_WIDTH
  - the width helper functions for IDX_W, DLY_W, SRC_WIDTH
  - the saturating-add function
- Sub-module spike_delay_ring holds slot storage, the head pointer, the clear-on-consume logic and the write port with conflict rule. The top level holds the decode, run counter, err and net_arstn.

## Test plan
- Reset, then SPK(idx 1, dly 0, val 5), RUN 1 with net_ready=1 → one cycle with net_valid=1 and net_inp[1]=5, others 0; next cycle net_valid=0 and the slot is cleared.
- SPK(0, dly 3, 7), RUN 5 → net_inp[0]=7 only on the 4th consumed frame; all other frames are 0.
- ACCUMULATE=1, CW=8: SPK(2,0,100) twice → net_inp[2]=127 (saturated). With ACCUMULATE=0 → 100.
- DEPTH=4: RUN 1 pending at run_counter=1 with net_ready=1, plus SPK(0, dly 3, 9) in the same cycle → the slot being vacated holds 9, which appears on the 4th frame with no residue.
- SPK(idx=NUM_INP, …) or dly=DEPTH → err=1 and no frame changes. A following CLR → err=0, net_arstn low for exactly one cycle, all frames 0.
- arstn asserted mid RUN 10 → net_valid=0, net_arstn=0 and net_inp all 0 immediately. After release, RUN 1 yields an all-zero frame.
